// File: rtl/counterup_sched_pkg.sv
// Shared constants and small index helpers for the round-robin counter scheduler.
package counterup_sched_pkg;

    localparam int NCH_DEFAULT   = 7;
    localparam int WIDTH_DEFAULT = 16;
    localparam int MAX_NCH       = 32;

    // One-hot vector of a channel index; callers cast down to their channel count.
    function automatic logic [MAX_NCH-1:0] onehot(input int idx);
        return MAX_NCH'(1) << idx;
    endfunction

    function automatic int next_index(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/counter_rr_arbiter.sv
// Rotating-priority picker: first pending channel at or above ptr, wrapping modulo NCH.
module counter_rr_arbiter #(
    parameter int NCH = 7,
    parameter int PW  = 3
) (
    input  logic [NCH-1:0] pending,
    input  logic [PW-1:0]  ptr,
    output logic           valid,
    output logic [PW-1:0]  index
);

    logic [PW-1:0] pos;

    always_comb begin
        valid = 1'b0;
        index = '0;
        pos   = '0;
        for (int k = 0; k < NCH; k++) begin
            pos = PW'((int'(ptr) + k) % NCH);
            if (!valid && pending[pos]) begin
                valid = 1'b1;
                index = pos;
            end
        end
    end

endmodule

// File: rtl/counterup16_rr_sched.sv
// Bank of NCH counters sharing one incrementer; pending requests are served round-robin.
module counterup16_rr_sched
    import counterup_sched_pkg::*;
#(
    parameter int NCH   = NCH_DEFAULT,
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 clear,
    input  logic [NCH-1:0]       req,
    output logic [NCH*WIDTH-1:0] cnt_all,
    output logic [NCH-1:0]       grant,
    output logic [NCH-1:0]       wrap,
    output logic [NCH-1:0]       drop,
    output logic                 busy
);

    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH-1:0]   pending;
    logic [PW-1:0]    ptr;
    logic [WIDTH-1:0] cnt [NCH];

    logic             arb_valid;
    logic [PW-1:0]    arb_index;
    logic             fire;
    logic [NCH-1:0]   sel_oh;
    logic [WIDTH-1:0] sel_cnt;
    logic [WIDTH-1:0] inc_cnt;
    logic [NCH-1:0]   pend_next;
    logic [NCH-1:0]   drop_next;
    logic [NCH-1:0]   wrap_next;

    counter_rr_arbiter #(.NCH(NCH), .PW(PW)) u_arb (
        .pending (pending),
        .ptr     (ptr),
        .valid   (arb_valid),
        .index   (arb_index)
    );

    // The single shared incrementer operates on whichever count the arbiter selected.
    always_comb begin
        fire      = enable & arb_valid;
        sel_oh    = fire ? NCH'(onehot(int'(arb_index))) : '0;
        sel_cnt   = cnt[arb_index];
        inc_cnt   = sel_cnt + 1'b1;
        pend_next = req | (pending & ~sel_oh);
        drop_next = req & pending & ~sel_oh;
        wrap_next = (sel_cnt == {WIDTH{1'b1}}) ? sel_oh : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending <= '0;
            ptr     <= '0;
            grant   <= '0;
            wrap    <= '0;
            drop    <= '0;
            for (int i = 0; i < NCH; i++) cnt[i] <= '0;
        end else if (clear) begin
            pending <= '0;
            ptr     <= '0;
            grant   <= '0;
            wrap    <= '0;
            drop    <= '0;
            for (int i = 0; i < NCH; i++) cnt[i] <= '0;
        end else begin
            pending <= pend_next;
            drop    <= drop_next;
            grant   <= sel_oh;
            wrap    <= wrap_next;
            if (fire) begin
                cnt[arb_index] <= inc_cnt;
                ptr            <= PW'(next_index(int'(arb_index), NCH));
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_pack
        assign cnt_all[g*WIDTH +: WIDTH] = cnt[g];
    end

    assign busy = |pending;

endmodule

// File: tb/tb_counterup16_rr_sched.sv
// Self-checking bench for counterup16_rr_sched: directed tables, corner sequences and random traffic.
module tb_counterup16_rr_sched;

    localparam int NCH   = 7;
    localparam int WIDTH = 16;
    localparam int MODV  = 1 << WIDTH;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 enable;
    logic                 clear;
    logic [NCH-1:0]       req;
    logic [NCH*WIDTH-1:0] cnt_all;
    logic [NCH-1:0]       grant;
    logic [NCH-1:0]       wrap;
    logic [NCH-1:0]       drop;
    logic                 busy;

    always #5 clk = ~clk;

    counterup16_rr_sched #(.NCH(NCH), .WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .clear   (clear),
        .req     (req),
        .cnt_all (cnt_all),
        .grant   (grant),
        .wrap    (wrap),
        .drop    (drop),
        .busy    (busy)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state: plain integer counts, a pending bit per channel and a pointer.
    int             cnt_m [NCH];
    bit             pend_m [NCH];
    int             ptr_m;
    logic [NCH-1:0] eg, ew, ed;

    typedef struct {
        logic [NCH-1:0] req;
        logic           en;
        logic           clr;
        logic [NCH-1:0] grant;
        logic [NCH-1:0] drop;
        logic           busy;
        int             cnt5;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [NCH*WIDTH-1:0] model_cnt_all();
        logic [NCH*WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < NCH; i++) v[i*WIDTH +: WIDTH] = WIDTH'(cnt_m[i]);
        return v;
    endfunction

    function automatic logic model_busy();
        logic b;
        b = 1'b0;
        for (int i = 0; i < NCH; i++) b |= pend_m[i];
        return b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            cnt_m[i]  = 0;
            pend_m[i] = 1'b0;
        end
        ptr_m = 0;
        eg = '0; ew = '0; ed = '0;
    endtask

    task automatic model_step(input logic [NCH-1:0] r, input logic en, input logic clr);
        int s;
        int c;
        s = -1;
        eg = '0; ew = '0; ed = '0;
        if (clr) begin
            model_reset();
            return;
        end
        if (en) begin
            for (int k = 0; k < NCH; k++) begin
                c = (ptr_m + k) % NCH;
                if (s < 0 && pend_m[c]) s = c;
            end
        end
        for (int i = 0; i < NCH; i++)
            if (r[i] && pend_m[i] && i != s) ed[i] = 1'b1;
        if (s >= 0) begin
            eg[s] = 1'b1;
            if (cnt_m[s] == MODV - 1) ew[s] = 1'b1;
            cnt_m[s]  = (cnt_m[s] + 1) % MODV;
            ptr_m     = (s + 1) % NCH;
            pend_m[s] = 1'b0;
        end
        for (int i = 0; i < NCH; i++)
            if (r[i]) pend_m[i] = 1'b1;
    endtask

    task automatic step(input logic [NCH-1:0] r, input logic en, input logic clr);
        req    = r;
        enable = en;
        clear  = clr;
        @(posedge clk);
        model_step(r, en, clr);
        #1;
    endtask

    task automatic compare_model(input string tag);
        check({tag, " grant"}, 128'(grant), 128'(eg));
        check({tag, " wrap"}, 128'(wrap), 128'(ew));
        check({tag, " drop"}, 128'(drop), 128'(ed));
        check({tag, " busy"}, 128'(busy), 128'(model_busy()));
        check({tag, " cnt_all"}, 128'(cnt_all), 128'(model_cnt_all()));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " outputs"}, 128'({grant, wrap, drop, busy}), 128'(0));
        check({tag, " cnt_all"}, 128'(cnt_all), 128'(0));
    endtask

    initial begin
        logic [NCH*WIDTH-1:0] exp_cnt;
        logic [NCH-1:0]       r;
        logic                 en, clr;

        // Reset held low with all requests active while the clock runs.
        reset = 1'b0; enable = 1'b1; clear = 1'b0; req = 7'h7F;
        model_reset();
        #1;
        check_all_zero("reset t0");
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check_all_zero($sformatf("reset cyc%0d", i));
        end
        #1 reset = 1'b1;
        step(7'h7F, 1'b1, 1'b0);
        check("post-reset first edge grant", 128'(grant), 128'(0));
        check("post-reset first edge busy", 128'(busy), 128'(1));
        step(7'h00, 1'b1, 1'b0);
        check("post-reset first grant", 128'(grant), 128'(7'h01));

        // Fairness sweep (continuing from pending=7E), clear, then drop-and-hold with enable low.
        tbl.push_back('{7'h00, 1'b1, 1'b0, 7'h02, 7'h00, 1'b1, 0});
        tbl.push_back('{7'h00, 1'b1, 1'b0, 7'h04, 7'h00, 1'b1, 0});
        tbl.push_back('{7'h00, 1'b1, 1'b0, 7'h08, 7'h00, 1'b1, 0});
        tbl.push_back('{7'h00, 1'b1, 1'b0, 7'h10, 7'h00, 1'b1, 0});
        tbl.push_back('{7'h00, 1'b1, 1'b0, 7'h20, 7'h00, 1'b1, 1});
        tbl.push_back('{7'h00, 1'b1, 1'b0, 7'h40, 7'h00, 1'b0, 1});
        tbl.push_back('{7'h00, 1'b1, 1'b0, 7'h00, 7'h00, 1'b0, 1});
        tbl.push_back('{7'h00, 1'b1, 1'b1, 7'h00, 7'h00, 1'b0, 0});
        tbl.push_back('{7'h20, 1'b0, 1'b0, 7'h00, 7'h00, 1'b1, 0});
        tbl.push_back('{7'h20, 1'b0, 1'b0, 7'h00, 7'h20, 1'b1, 0});
        tbl.push_back('{7'h20, 1'b0, 1'b0, 7'h00, 7'h20, 1'b1, 0});
        tbl.push_back('{7'h00, 1'b1, 1'b0, 7'h20, 7'h00, 1'b0, 1});
        tbl.push_back('{7'h00, 1'b1, 1'b0, 7'h00, 7'h00, 1'b0, 1});
        exp_cnt = '0;
        for (int i = 0; i < NCH; i++) exp_cnt[i*WIDTH +: WIDTH] = WIDTH'(1);
        for (int v = 0; v < tbl.size(); v++) begin
            step(tbl[v].req, tbl[v].en, tbl[v].clr);
            check($sformatf("tbl%0d grant", v), 128'(grant), 128'(tbl[v].grant));
            check($sformatf("tbl%0d drop", v), 128'(drop), 128'(tbl[v].drop));
            check($sformatf("tbl%0d busy", v), 128'(busy), 128'(tbl[v].busy));
            check($sformatf("tbl%0d cnt5", v), 128'(cnt_all[5*WIDTH +: WIDTH]), 128'(tbl[v].cnt5));
            if (v == 6) check("fairness all counts 1", 128'(cnt_all), 128'(exp_cnt));
        end

        // Clear takes precedence over requests, pending flags and a possible grant.
        step(7'h7F, 1'b0, 1'b0);
        step(7'h7F, 1'b1, 1'b1);
        check("clear prec outputs", 128'({grant, drop, busy}), 128'(0));
        check("clear prec counts", 128'(cnt_all), 128'(0));
        step(7'h00, 1'b1, 1'b0);
        check("clear discards req", 128'({grant, busy}), 128'(0));

        // Single request on channel 3.
        step(7'h08, 1'b1, 1'b0);
        check("single first edge grant", 128'(grant), 128'(0));
        step(7'h00, 1'b1, 1'b0);
        check("single grant", 128'(grant), 128'(7'h08));
        check("single cnt_all", 128'(cnt_all), 128'(1) << (3*WIDTH));
        step(7'h00, 1'b1, 1'b0);
        check("single after", 128'({grant, busy}), 128'(0));

        // Re-request on the granting edge keeps the flag set without a drop.
        step(7'h02, 1'b1, 1'b0);
        step(7'h02, 1'b1, 1'b0);
        check("rereq grant", 128'(grant), 128'(7'h02));
        check("rereq no drop", 128'(drop), 128'(0));
        check("rereq busy", 128'(busy), 128'(1));
        step(7'h00, 1'b1, 1'b0);
        check("rereq second grant", 128'(grant), 128'(7'h02));

        // Channel 0 wraps after 65536 grants.
        step(7'h00, 1'b1, 1'b1);
        step(7'h01, 1'b1, 1'b0);
        for (int n = 1; n <= MODV; n++) begin
            step(7'h01, 1'b1, 1'b0);
            compare_model($sformatf("wrap n%0d", n));
            if (n == MODV - 1) begin
                check("wrap pre cnt0", 128'(cnt_all[WIDTH-1:0]), 128'(16'hFFFF));
                check("wrap pre pulse", 128'(wrap), 128'(0));
            end
            if (n == MODV) begin
                check("wrap cnt0", 128'(cnt_all[WIDTH-1:0]), 128'(0));
                check("wrap pulse", 128'(wrap), 128'(7'h01));
                check("wrap grant", 128'(grant), 128'(7'h01));
            end
        end
        step(7'h00, 1'b1, 1'b0);
        check("wrap one cycle", 128'(wrap), 128'(0));
        check("wrap next cnt0", 128'(cnt_all[WIDTH-1:0]), 128'(1));

        // Random traffic against the model, with occasional asynchronous resets.
        for (int i = 0; i < 3000; i++) begin
            if (i % 700 == 350) begin
                #2 reset = 1'b0;
                req = NCH'($urandom);
                #1;
                check_all_zero($sformatf("rand async reset %0d", i));
                model_reset();
                @(posedge clk);
                #1;
                check_all_zero($sformatf("rand reset held %0d", i));
                #1 reset = 1'b1;
            end
            r   = NCH'($urandom) & NCH'($urandom);
            en  = ($urandom_range(0, 9) != 0);
            clr = ($urandom_range(0, 49) == 0);
            step(r, en, clr);
            compare_model($sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/counterup16_rr_sched.md
COUNTERUP16_RR_SCHED -- requirements
Module: counterup16_rr_sched

Interface
REQ-001 The block SHALL have the parameter NCH, default 7, giving the number of counter channels.
REQ-002 The block SHALL have the parameter WIDTH, default 16, giving the counter width in bits.
REQ-003 Port clk, input, 1: single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-low reset; low SHALL force the reset state immediately.
REQ-005 Port enable, input, 1: high allows grants; low SHALL freeze arbitration while pending requests still accumulate.
REQ-006 Port clear, input, 1: synchronous clear of counts, pending flags and the pointer.
REQ-007 Port req, input, NCH: per-channel increment request, sampled on each rising edge.
REQ-008 Port cnt_all, output, NCH*WIDTH: registered counts; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-009 Port grant, output, NCH: registered one-hot; bit i high marks the cycle after channel i was incremented.
REQ-010 Port wrap, output, NCH: registered one-cycle pulse when a granted count goes from all-ones to 0.
REQ-011 Port drop, output, NCH: registered one-cycle pulse when a request is lost.
REQ-012 Port busy, output, 1: combinational OR of all pending flags.

Function
REQ-013 Each channel SHALL have one pending flag; req[i] high at an edge SHALL set pending[i].
REQ-014 A single shared WIDTH-bit incrementer SHALL serve all channels; at most one count SHALL change per edge.
REQ-015 Arbitration SHALL select from the pending register state only, never from same-cycle req.
REQ-016 Selection SHALL be round-robin: search starts at pointer ptr (0..NCH-1) and proceeds upward with modulo wrap.
REQ-017 On a grant to channel s: count[s] += 1 modulo 2^WIDTH, pending[s] cleared, ptr = (s+1) mod NCH, and grant = onehot(s) is registered.
REQ-018 If req[s] is high on the same edge that s is granted, pending[s] SHALL remain set, with no drop.
REQ-019 If req[i] is high while pending[i] is set and i is not granted on that edge, drop[i] SHALL pulse for one cycle and pending[i] SHALL stay 1.
REQ-020 Latency: a request sampled at edge E0 SHALL produce, at the earliest, a count update and grant at edge E1.
REQ-021 With enable low: no grant; counts and ptr hold; grant = 0; pending and drop behave per REQ-013/019.
REQ-022 wrap[s] SHALL assert together with grant[s] when count[s] was 2^WIDTH-1 before the increment.
REQ-023 clear high SHALL zero counts, pending, ptr, grant, wrap and drop at the edge, taking precedence over req and grant; requests present on that edge SHALL be discarded without a drop pulse.
REQ-024 When no flag is pending, the block SHALL make no grant and ptr SHALL hold.

Reset
REQ-025 While reset is low, cnt_all, pending, grant, wrap and drop SHALL be 0, ptr SHALL be 0 and busy SHALL be 0, independent of clk.
REQ-026 Reset asserted mid-operation SHALL discard all pending requests; the first grant after release SHALL start the search at channel 0.

Structure
REQ-027 Constants NCH_DEFAULT=7 and WIDTH_DEFAULT=16, plus the onehot/index helper function, SHALL reside in the shared package counterup_sched_pkg.
REQ-028 Rotating-priority selection SHALL be a sub-module counter_rr_arbiter with inputs pending and ptr and outputs valid and index.
REQ-029 The block SHALL contain exactly one WIDTH-bit incrementer, muxed by the arbiter index.

Verification
REQ-030 Reset: hold reset low with req=7'h7F and a toggling clk -> all outputs 0 throughout; the first grant after release is grant=7'h01.
REQ-031 Single request: req=7'h08 for one edge, enable=1 -> the next edge gives grant=7'h08, cnt3=1, then busy=0 and grant=0.
REQ-032 Fairness: req=7'h7F for one edge -> grants 01,02,04,...,40 on 7 consecutive edges; every count = 1; drop never asserts.
REQ-033 Wrap: issue 65536 spaced requests on channel 0 -> the final grant gives cnt0=0 with wrap=7'h01 for exactly one cycle.
REQ-034 Drop and hold: enable=0, then req=7'h20 on 3 edges -> drop[5] pulses twice and cnt5 stays 0; with enable=1 -> one grant, cnt5=1.
REQ-035 Clear precedence: clear=1 with req=7'h7F and pending=7'h7F -> next cycle counts=0, busy=0, drop=0 and grant=0.
